fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core, sitting directly upstream of `decoder`. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel. It collects in-order responses into a small buffer and presents `instruction` and its PC to the decoder over a valid/ready handshake. A redirect input (branch/jump/trap target) flushes buffered and in-flight fetches and restarts fetch at the new PC.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Core-wide constants and the buffered fetch entry type shared by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous clear; head reads as zero while empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited memory requests, buffers in-order
// responses for the decoder, and discards stale responses after a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count, tag_count;
  logic            fifo_full, fifo_empty, tag_full, tag_empty;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    head, rsp_entry;

  logic credit, req_fire, rsp_keep, rsp_drop, pop_fire;

  // Credit counts current-state occupancy only; a same-cycle pop does not help.
  assign credit = ((32'(inflight_q) + 32'(fifo_count)) < DEPTH) && !fifo_full && !tag_full;

  assign imem_req_valid = rst_n && credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !tag_empty;

  assign instr_valid = !fifo_empty;
  assign instruction = head.word;
  assign instr_pc    = head.pc;
  assign pop_fire    = instr_valid && instr_ready;

  assign rsp_entry.pc   = tag_pc;
  assign rsp_entry.word = imem_rsp_data;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d = drop_cnt_q - CW'(rsp_drop);

    if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);

    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      // Everything still outstanding after this edge is stale: already-stale requests
      // plus every tagged request, including one accepted this cycle.
      drop_cnt_d = drop_cnt_q + tag_count + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= align_pc(RESET_PC);
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // PCs of live requests, in issue order; cleared on redirect since all become stale.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .pop_data  (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (pop_fire),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, word} pairs,
// a monitor pops and compares on every decoder handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;

  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        rsp_valid2;
  logic [31:0] rsp_data2;
  logic        instr_valid2;
  logic [31:0] instruction2, instr_pc2;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req_valid2),
    .imem_req_ready (1'b1),
    .imem_req_addr  (req_addr2),
    .imem_rsp_valid (rsp_valid2),
    .imem_rsp_data  (rsp_data2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .instr_valid    (instr_valid2),
    .instr_ready    (1'b1),
    .instruction    (instruction2),
    .instr_pc       (instr_pc2)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back('{pc, word});
  endtask

  // Memory model for dut: in-order, latency lat, word = addr ^ 0x13.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];
  int    cyc = 0;
  int    lat = 1;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_q[0].addr ^ 32'h13;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
    end else begin
      if (imem_rsp_valid) void'(pend_q.pop_front());
      if (imem_req_valid && imem_req_ready) pend_q.push_back('{imem_req_addr, cyc + lat});
    end
  end

  // Scoreboard monitor: a handshake in a redirect cycle is discarded by the DUT.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc=%h word=%h, expected none", instr_pc,
                 instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", instr_pc, e.pc);
        check("out_word", instruction, e.word);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && dut.u_instr_fifo.push && dut.u_instr_fifo.full && !dut.u_instr_fifo.pop &&
        !dut.u_instr_fifo.clear) begin
      checks++;
      errors++;
      $display("FAIL fifo_overflow: got push into full FIFO, expected none");
    end
  end

  // dut2: 1-cycle memory, always ready, logs its first requests and outputs.
  logic        acc2;
  logic [31:0] a2;
  logic [31:0] log2[$];
  logic [31:0] out2[$];
  logic [31:0] outw2[$];

  always @(negedge clk) begin
    acc2 = rst_n && req_valid2;
    a2   = req_addr2;
    if (acc2 && log2.size() < 3) log2.push_back(a2);
    if (rst_n && instr_valid2 && out2.size() < 3) begin
      out2.push_back(instr_pc2);
      outw2.push_back(instruction2);
    end
  end

  always @(posedge clk) begin
    #2;
    rsp_valid2 = acc2;
    rsp_data2  = a2 ^ 32'h13;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    instr_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    instr_ready = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    rsp_valid2     = 1'b0;
    rsp_data2      = 32'h0;
    acc2           = 1'b0;
    a2             = 32'h0;

    // Reset held for 3 edges.
    tick(2);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    tick(1);
    rst_n = 1'b1;

    // Streaming, 1-cycle memory.
    push_exp(32'h00, 32'h13);
    push_exp(32'h04, 32'h17);
    push_exp(32'h08, 32'h1B);
    push_exp(32'h0C, 32'h1F);
    push_exp(32'h10, 32'h03);
    push_exp(32'h14, 32'h07);
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    tick(1);
    drain(60);

    // Back-pressure: buffer fills, requests stop, head held.
    tick(6);
    @(negedge clk);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_count", 32'(dut.u_instr_fifo.count), 32'd2);
    check("bp_inflight", 32'(dut.inflight_q), 32'd0);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_head_pc", instr_pc, 32'h18);
    tick(3);
    @(negedge clk);
    check("bp_hold_valid", 32'(instr_valid), 32'd1);
    check("bp_hold_pc", instr_pc, 32'h18);
    check("bp_hold_word", instruction, 32'h0B);
    tick(1);
    push_exp(32'h18, 32'h0B);
    push_exp(32'h1C, 32'h0F);
    push_exp(32'h20, 32'h33);
    push_exp(32'h24, 32'h37);
    drain(60);

    // 3-cycle memory, redirect with two requests in flight.
    tick(6);
    lat            = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick(1);
    redirect_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk);
      #3;
      if (dut.inflight_q == 2 && !imem_rsp_valid && dut.u_instr_fifo.count == 0 &&
          dut.drop_cnt_q == 0) begin
        hit            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
      end
    end
    check("redir_setup", 32'(hit), 32'd1);
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_addr", imem_req_addr, 32'h100);
    check("redir_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    check("redir_valid", 32'(instr_valid), 32'd0);
    push_exp(32'h100, 32'h113);
    push_exp(32'h104, 32'h117);
    tick(1);
    drain(60);

    // Redirect coinciding with a response and a decoder pop.
    lat            = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick(1);
    redirect_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk);
      #3;
      if (instr_valid && imem_rsp_valid && dut.drop_cnt_q == 0) begin
        hit            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        instr_ready    = 1'b1;
      end
    end
    check("coinc_setup", 32'(hit), 32'd1);
    tick(1);
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    @(negedge clk);
    check("coinc_valid", 32'(instr_valid), 32'd0);
    check("coinc_count", 32'(dut.u_instr_fifo.count), 32'd0);
    check("coinc_addr", imem_req_addr, 32'h500);
    push_exp(32'h500, 32'h513);
    push_exp(32'h504, 32'h517);
    tick(1);
    drain(60);

    // Mid-stream reset with two entries buffered.
    tick(8);
    @(negedge clk);
    check("mid_count", 32'(dut.u_instr_fifo.count), 32'd2);
    tick(1);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instruction", instruction, 32'h0);
    check("mid_rst_pc", instr_pc, 32'h0);
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_addr", imem_req_addr, 32'h0);
    check("mid_rst_inflight", 32'(dut.inflight_q), 32'd0);
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_req_valid", 32'(imem_req_valid), 32'd1);
    check("restart_addr", imem_req_addr, 32'h0);
    push_exp(32'h0, 32'h13);
    push_exp(32'h4, 32'h17);
    tick(1);
    drain(60);

    // Wrap instance.
    check("wrap_req_count", 32'(log2.size()), 32'd3);
    check("wrap_out_count", 32'(out2.size()), 32'd3);
    if (log2.size() == 3) begin
      check("wrap_req0", log2[0], 32'hFFFF_FFF8);
      check("wrap_req1", log2[1], 32'hFFFF_FFFC);
      check("wrap_req2", log2[2], 32'h0000_0000);
    end
    if (out2.size() == 3) begin
      check("wrap_out_pc0", out2[0], 32'hFFFF_FFF8);
      check("wrap_out_pc1", out2[1], 32'hFFFF_FFFC);
      check("wrap_out_pc2", out2[2], 32'h0000_0000);
      check("wrap_out_word2", outw2[2], 32'h0000_0013);
    end

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
